// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM encoding,
// the per-element March table and the memory read latency.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NUM_ELEM = 6;
    localparam int READ_LAT = 2;
    localparam logic [2:0] ELEM_LAST = 3'd5;

    // One bit per element, bit index = element number (E0 is bit 0).
    // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    localparam logic [NUM_ELEM-1:0] EL_DOWN      = 6'b011000;
    localparam logic [NUM_ELEM-1:0] EL_HAS_READ  = 6'b111110;
    localparam logic [NUM_ELEM-1:0] EL_RBG       = 6'b010100;
    localparam logic [NUM_ELEM-1:0] EL_HAS_WRITE = 6'b011111;
    // E5 has no write; its background matches E4 so mem_wdata stays put.
    localparam logic [NUM_ELEM-1:0] EL_WBG       = 6'b001010;

    function automatic logic el_two_op(input logic [2:0] elem);
        return EL_HAS_READ[elem] & EL_HAS_WRITE[elem];
    endfunction

endpackage

// File: rtl/mbist_rd_cmp.sv
// Read-latency alignment pipe, read-data comparator and first-failure capture
// with a saturating miscompare counter.
module mbist_rd_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [2:0]            in_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  miscmp,
    output logic                  fail,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
);

    logic [READ_LAT-1:0]   vld_r;
    logic [DATA_WIDTH-1:0] exp_r  [READ_LAT];
    logic [ADDR_WIDTH-1:0] addr_r [READ_LAT];
    logic [2:0]            elem_r [READ_LAT];

    // Shift issued-read info so it meets its data on mem_rdata.
    always_ff @(posedge clk) begin
        if (rst || clear || flush) begin
            vld_r <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                exp_r[i]  <= '0;
                addr_r[i] <= '0;
                elem_r[i] <= 3'd0;
            end
        end else begin
            vld_r[0]  <= in_valid;
            exp_r[0]  <= in_exp;
            addr_r[0] <= in_addr;
            elem_r[0] <= in_elem;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1];
                exp_r[i]  <= exp_r[i-1];
                addr_r[i] <= addr_r[i-1];
                elem_r[i] <= elem_r[i-1];
            end
        end
    end

    assign miscmp = vld_r[READ_LAT-1] && (rdata != exp_r[READ_LAT-1]);

    // Sticky fail flag, saturating count, and first-failure snapshot.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail       <= 1'b0;
            fail_count <= 8'd0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            fail_data  <= '0;
        end else if (miscmp) begin
            fail <= 1'b1;
            if (fail_count != 8'hFF) begin
                fail_count <= fail_count + 8'd1;
            end else begin
                fail_count <= fail_count;
            end
            if (!fail) begin
                fail_addr <= addr_r[READ_LAT-1];
                fail_elem <= elem_r[READ_LAT-1];
                fail_data <= rdata;
            end else begin
                fail_addr <= fail_addr;
                fail_elem <= fail_elem;
                fail_data <= fail_data;
            end
        end else begin
            fail <= fail;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for one single-port memory: element/address/op
// sequencing, registered memory commands and pass/fail reporting.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int ADDR_LAST    = 2**ADDR_WIDTH - 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST_V = ADDR_WIDTH'(ADDR_LAST);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

    state_t                state_r, state_n;
    logic [2:0]            elem_r, elem_n, elem_nx_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n, end_addr_s;
    logic                  phase_r, phase_n;
    logic                  op_last_s, run_n_s, op_wr_n_s;
    logic                  clear_s, flush_s, miscmp_s;
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_exp_r;

    // phase_r: 0 = read slot, 1 = write slot; in DRAIN it counts the two cycles.
    assign op_last_s  = ~el_two_op(elem_r) | phase_r;
    assign end_addr_s = EL_DOWN[elem_r] ? '0 : ADDR_LAST_V;
    assign run_n_s    = (state_n == ST_RUN);
    assign op_wr_n_s  = EL_HAS_READ[elem_n] ? phase_n : 1'b1;

    // Next-state, counter update and stop-on-fail override.
    always_comb begin
        state_n   = state_r;
        elem_n    = elem_r;
        addr_n    = addr_r;
        phase_n   = phase_r;
        clear_s   = 1'b0;
        flush_s   = 1'b0;
        elem_nx_s = elem_r + 3'd1;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_SETUP;
                    elem_n  = 3'd0;
                    addr_n  = '0;
                    phase_n = 1'b0;
                    clear_s = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            ST_SETUP: begin
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!op_last_s) begin
                    phase_n = 1'b1;
                end else if (addr_r != end_addr_s) begin
                    phase_n = 1'b0;
                    addr_n  = EL_DOWN[elem_r] ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                end else if (elem_r == ELEM_LAST) begin
                    phase_n = 1'b0;
                    state_n = ST_DRAIN;
                end else begin
                    phase_n = 1'b0;
                    elem_n  = elem_nx_s;
                    addr_n  = EL_DOWN[elem_nx_s] ? ADDR_LAST_V : '0;
                end
            end
            ST_DRAIN: begin
                if (phase_r) begin
                    state_n = ST_DONE;
                    phase_n = 1'b0;
                end else begin
                    phase_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (STOP_ON_FAIL && miscmp_s) begin
            state_n = ST_DONE;
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    // State, counters and registered memory command / status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            elem_r         <= 3'd0;
            addr_r         <= '0;
            phase_r        <= 1'b0;
            mem_write_read <= 1'b0;
            mem_wdata      <= '0;
            rd_valid_r     <= 1'b0;
            rd_exp_r       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r        <= state_n;
            elem_r         <= elem_n;
            addr_r         <= addr_n;
            phase_r        <= phase_n;
            mem_write_read <= run_n_s & op_wr_n_s;
            rd_valid_r     <= run_n_s & ~op_wr_n_s;
            rd_exp_r       <= {DATA_WIDTH{EL_RBG[elem_n]}};
            busy           <= (state_n == ST_SETUP) || (state_n == ST_RUN) || (state_n == ST_DRAIN);
            done           <= (state_n == ST_DONE);
            // Background changes only on element entry, ahead of that element's first write.
            if (state_n == ST_SETUP) begin
                mem_wdata <= '0;
            end else if (run_n_s) begin
                mem_wdata <= {DATA_WIDTH{EL_WBG[elem_n]}};
            end else begin
                mem_wdata <= mem_wdata;
            end
        end
    end

    assign mem_address = addr_r;

    mbist_rd_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .flush      (flush_s),
        .in_valid   (rd_valid_r),
        .in_exp     (rd_exp_r),
        .in_addr    (addr_r),
        .in_elem    (elem_r),
        .rdata      (mem_rdata),
        .miscmp     (miscmp_s),
        .fail       (fail),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_data  (fail_data)
    );

endmodule
